create_msg_queue: RTL and testbench
===================================

Name: create_msg_queue

Overview:
- Sits between session_manager and the create message stage.
- Captures every message request from session_manager (initiate_msg + type + target CompID) into a small FIFO, so no request is lost while the create message stage is busy.
- Issues queued requests one at a time with a start/done handshake.
- Drops redundant heartbeat requests and guards the handshake with a watchdog.

Parameters:
- NUM_HOST, `HOST_ADDR_WIDTH, width of host/session index.
- VALUE_WIDTH, `VALUE_DATA_WIDTH, width of TargetCompID value.
- SIZE, `VALUE_SIZE, width of TargetCompID size field.
- DEPTH_LOG2, 2, log2 of FIFO depth (default 4 entries).
- WDOG_CYCLES, 1023, max cycles to wait for done_i after start_o.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- initiate_msg_i  in  1  request strobe from session_manager
- create_message_i  in  4  message type (`logon, `logout, `heartbeat, `resendReq)
- host_i  in  NUM_HOST  session index of request
- targetCompId_i  in  VALUE_WIDTH  TargetCompID value
- s_v_targetCompId_i  in  SIZE  TargetCompID size
- busy_i  in  1  create message stage busy
- done_i  in  1  create message stage finished current message (1-cycle pulse)
- start_o  out  1  1-cycle launch pulse to create message
- msg_type_o  out  4  type of launched message
- host_o  out  NUM_HOST  session of launched message
- targetCompId_o  out  VALUE_WIDTH  launched TargetCompID
- s_v_targetCompId_o  out  SIZE  launched TargetCompID size
- full_o  out  1  FIFO full
- count_o  out  DEPTH_LOG2+1  occupied entries
- drop_o  out  1  1-cycle pulse: request discarded (overflow or heartbeat merge)
- wdog_err_o  out  1  1-cycle pulse: done_i not received in time

Behaviour:
- Reset (rst=0, async):
  - All outputs 0.
  - FIFO pointers 0, count 0, FSM in IDLE, watchdog counter 0.
- Push:
  - Occurs on a rising edge with initiate_msg_i=1 and create_message_i!=0.
  - Type 0 is ignored; no drop_o.
  - Entry = {type, host, compId, size}.
- Heartbeat merge: a push with type=`heartbeat is discarded (drop_o=1 next cycle) if an entry with type `heartbeat and the same host already sits in the FIFO. The in-flight entry does not count.
- Overflow:
  - A push while count=DEPTH and no same-cycle pop is discarded, with drop_o=1 next cycle.
  - Push and pop in the same cycle at full are both accepted; count is unchanged.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE: if count>0 and busy_i=0, go to ISSUE.
  - ISSUE (one cycle):
    - start_o=1.
    - msg_type_o/host_o/targetCompId_o/s_v_targetCompId_o are loaded from the head entry in the same cycle.
    - Head is popped; go to WAIT_DONE.
  - WAIT_DONE:
    - Data outputs hold stable.
    - done_i=1: go to IDLE.
    - Watchdog reaches WDOG_CYCLES without done_i: wdog_err_o=1 for one cycle, go to IDLE.
    - Watchdog clears on entry to WAIT_DONE.
- Latency:
  - Push at edge N into an empty FIFO with busy_i=0: IDLE sees count>0 after edge N, ISSUE state after edge N+1, start_o high during cycle N+1..N+2.
  - Minimum issue-to-issue spacing is 3 cycles (ISSUE, WAIT_DONE with done_i, IDLE).
- done_i outside WAIT_DONE is ignored.
- busy_i is sampled only in IDLE.
- Pointers wrap modulo 2^DEPTH_LOG2.
- full_o = (count=DEPTH); count_o is the registered count.
- Order is strict FIFO; there is no priority between types.

Test Plan:
- Single request: push `logon, host=2, compId=0xABCD, busy_i=0 → start_o one cycle 2 cycles later with msg_type_o=`logon, host_o=2; done_i 3 cycles later → IDLE, count_o=0.
- Backpressure: busy_i=1 while pushing `logon(h0), `heartbeat(h1), `resendReq(h2) → no start_o, count_o=3. Release busy_i with done_i after each start → three start_o pulses in push order.
- Overflow: busy_i=1, push 5 distinct requests → count_o=4, full_o=1, drop_o one pulse on the 5th push; FIFO holds the first 4.
- Heartbeat merge: push `heartbeat(h1) twice while busy → second push gives drop_o, count_o=1. Push `heartbeat(h3) → accepted, count_o=2.
- Watchdog: issue one request, never assert done_i → wdog_err_o pulses exactly WDOG_CYCLES cycles after entering WAIT_DONE; next queued entry then issues.
- Async reset mid-WAIT_DONE with 2 entries queued: rst low → outputs 0 immediately, count_o=0. After rst release, no start_o until a new push.

Source files
------------

// File: rtl/create_msg_queue.sv
// Request queue between session_manager and the create message stage: buffers
// message requests, merges duplicate heartbeats and launches one at a time.
module create_msg_queue #(
  parameter int unsigned NUM_HOST    = 8,
  parameter int unsigned VALUE_WIDTH = 32,
  parameter int unsigned SIZE        = 8,
  parameter int unsigned DEPTH_LOG2  = 2,
  parameter int unsigned WDOG_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   initiate_msg_i,
  input  logic [3:0]             create_message_i,
  input  logic [NUM_HOST-1:0]    host_i,
  input  logic [VALUE_WIDTH-1:0] targetCompId_i,
  input  logic [SIZE-1:0]        s_v_targetCompId_i,
  input  logic                   busy_i,
  input  logic                   done_i,
  output logic                   start_o,
  output logic [3:0]             msg_type_o,
  output logic [NUM_HOST-1:0]    host_o,
  output logic [VALUE_WIDTH-1:0] targetCompId_o,
  output logic [SIZE-1:0]        s_v_targetCompId_o,
  output logic                   full_o,
  output logic [DEPTH_LOG2:0]    count_o,
  output logic                   drop_o,
  output logic                   wdog_err_o
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [3:0]  MSG_HEARTBEAT = 4'h3;

  typedef struct packed {
    logic [3:0]             msg_type;
    logic [NUM_HOST-1:0]    host;
    logic [VALUE_WIDTH-1:0] comp_id;
    logic [SIZE-1:0]        size;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  entry_t              fifo_q [DEPTH];
  entry_t              entry_in;
  entry_t              out_q, out_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  logic                drop_q, drop_d;
  logic                start_q, start_d;
  logic                err_q, err_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                push_req, push, pop, hb_dup, overflow;
  logic [PTR_W-1:0]    off, idx;

  assign entry_in = '{msg_type: create_message_i, host: host_i,
                      comp_id: targetCompId_i, size: s_v_targetCompId_i};

  // Queue bookkeeping; the entry being launched this cycle no longer counts for merging
  always_comb begin
    push_req = initiate_msg_i && (create_message_i != 4'h0);
    pop      = (state_q == IDLE) && (count_q != '0) && !busy_i;
    hb_dup   = 1'b0;
    off      = '0;
    idx      = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = PTR_W'(i);
      off = idx - rd_ptr_q;
      if ((CNT_W'(off) < count_q) && !(pop && (off == '0)) &&
          (fifo_q[idx].msg_type == MSG_HEARTBEAT) && (fifo_q[idx].host == host_i)) begin
        hb_dup = 1'b1;
      end
    end
    hb_dup   = hb_dup && (create_message_i == MSG_HEARTBEAT);
    overflow = (count_q == CNT_W'(DEPTH)) && !pop;
    push     = push_req && !hb_dup && !overflow;
    drop_d   = push_req && (hb_dup || overflow);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d   = (count_d == CNT_W'(DEPTH));
  end

  // Launch FSM: next state, registered launch outputs and watchdog
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ISSUE;
          start_d = 1'b1;
          out_d   = fifo_q[rd_ptr_q];
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
        wdog_d  = '0;
      end
      WAIT_DONE: begin
        if (done_i) begin
          state_d = IDLE;
        end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= entry_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      drop_q   <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      drop_q   <= drop_d;
      start_q  <= start_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  assign start_o            = start_q;
  assign msg_type_o         = out_q.msg_type;
  assign host_o             = out_q.host;
  assign targetCompId_o     = out_q.comp_id;
  assign s_v_targetCompId_o = out_q.size;
  assign full_o             = full_q;
  assign count_o            = count_q;
  assign drop_o             = drop_q;
  assign wdog_err_o         = err_q;

endmodule

// File: tb/tb_create_msg_queue.sv
// Bench for create_msg_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_create_msg_queue;

  localparam int unsigned NH    = 8;
  localparam int unsigned VW    = 16;
  localparam int unsigned SW    = 8;
  localparam int unsigned DL2   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WDOG  = 16;

  localparam logic [3:0] T_LOGON  = 4'h1;
  localparam logic [3:0] T_LOGOUT = 4'h2;
  localparam logic [3:0] T_HB     = 4'h3;
  localparam logic [3:0] T_RESEND = 4'h4;

  typedef struct packed {
    logic [3:0]    t;
    logic [NH-1:0] h;
    logic [VW-1:0] c;
    logic [SW-1:0] s;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          init;
  logic [3:0]    mtype;
  logic [NH-1:0] host;
  logic [VW-1:0] comp;
  logic [SW-1:0] size;
  logic          busy;
  logic          done;
  logic          start_o, full_o, drop_o, wdog_err_o;
  logic [3:0]    msg_type_o;
  logic [NH-1:0] host_o;
  logic [VW-1:0] comp_o;
  logic [SW-1:0] size_o;
  logic [DL2:0]  count_o;

  int n_checks = 0;
  int n_pass   = 0;

  create_msg_queue #(
    .NUM_HOST(NH), .VALUE_WIDTH(VW), .SIZE(SW), .DEPTH_LOG2(DL2), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst(rst),
    .initiate_msg_i(init), .create_message_i(mtype), .host_i(host),
    .targetCompId_i(comp), .s_v_targetCompId_i(size),
    .busy_i(busy), .done_i(done),
    .start_o(start_o), .msg_type_o(msg_type_o), .host_o(host_o),
    .targetCompId_o(comp_o), .s_v_targetCompId_o(size_o),
    .full_o(full_o), .count_o(count_o), .drop_o(drop_o), .wdog_err_o(wdog_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference model: pending requests as a queue, one message in flight aged in cycles
  ent_t mq[$];
  ent_t e_out;
  bit   e_start, e_drop, e_err, in_flight, was_free, dup;
  int   age;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      e_out = '0; e_start = 0; e_drop = 0; e_err = 0; in_flight = 0; age = 0;
    end else begin
      was_free = !in_flight;
      e_start = 0; e_drop = 0; e_err = 0;
      if (in_flight) begin
        age++;
        if (age >= 2) begin
          if (done) in_flight = 0;
          else if (age == int'(WDOG) + 1) begin e_err = 1; in_flight = 0; end
        end
      end
      if (was_free && mq.size() > 0 && !busy) begin
        e_out = mq.pop_front();
        e_start = 1; in_flight = 1; age = 0;
      end
      if (init && mtype != 4'h0) begin
        dup = 0;
        if (mtype == T_HB)
          foreach (mq[k]) if (mq[k].t == T_HB && mq[k].h == host) dup = 1;
        if (dup || mq.size() == int'(DEPTH)) e_drop = 1;
        else mq.push_back('{t: mtype, h: host, c: comp, s: size});
      end
    end
  end

  always @(negedge clk) begin
    if (rst)
      chk("cycle_outputs",
          64'({start_o, msg_type_o, host_o, comp_o, size_o, full_o, count_o, drop_o, wdog_err_o}),
          64'({e_start, e_out, mq.size() == int'(DEPTH), 3'(mq.size()), e_drop, e_err}));
  end

  task automatic push(input logic [3:0] t, input logic [NH-1:0] h,
                      input logic [VW-1:0] c, input logic [SW-1:0] s);
    init = 1'b1; mtype = t; host = h; comp = c; size = s;
    @(negedge clk);
    init = 1'b0; mtype = 4'h0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start_o) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_start: start_o not seen within 20 cycles");
    end
  endtask

  task automatic complete();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic launch_check(input logic [3:0] t, input logic [NH-1:0] h);
    bit ok;
    wait_start(ok);
    if (ok) begin
      chk("launch_type", 64'(msg_type_o), 64'(t));
      chk("launch_host", 64'(host_o), 64'(h));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int cyc;
    rst = 1'b1; init = 0; mtype = 0; host = 0; comp = 0; size = 0; busy = 0; done = 0;
    #1 rst = 1'b0;
    #1;
    chk("rst_start", 64'(start_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_type", 64'(msg_type_o), 64'd0);
    chk("rst_err_drop", 64'({wdog_err_o, drop_o}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single request: launch two edges after the push
    push(T_LOGON, 8'd2, 16'hABCD, 8'd4);
    chk("t1_count_after_push", 64'(count_o), 64'd1);
    chk("t1_no_start_yet", 64'(start_o), 64'd0);
    @(negedge clk);
    chk("t1_start", 64'(start_o), 64'd1);
    chk("t1_type", 64'(msg_type_o), 64'(T_LOGON));
    chk("t1_host", 64'(host_o), 64'd2);
    chk("t1_comp", 64'(comp_o), 64'hABCD);
    chk("t1_count_popped", 64'(count_o), 64'd0);
    @(negedge clk);
    chk("t1_start_one_cycle", 64'(start_o), 64'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("t1_count_end", 64'(count_o), 64'd0);

    // Backpressure: nothing launches while busy, then strict push order
    busy = 1'b1;
    push(T_LOGON, 8'd0, 16'h0010, 8'd1);
    push(T_HB, 8'd1, 16'h0011, 8'd1);
    push(T_RESEND, 8'd2, 16'h0012, 8'd1);
    repeat (4) @(negedge clk);
    chk("t2_count", 64'(count_o), 64'd3);
    chk("t2_no_start", 64'(start_o), 64'd0);
    busy = 1'b0;
    launch_check(T_LOGON, 8'd0);  complete();
    launch_check(T_HB, 8'd1);     complete();
    launch_check(T_RESEND, 8'd2); complete();

    // Overflow: fifth request dropped, first four retained
    busy = 1'b1;
    for (int i = 0; i < 5; i++) push(T_LOGON, NH'(i), VW'(16'h100 + i), SW'(i));
    chk("t3_drop", 64'(drop_o), 64'd1);
    chk("t3_count", 64'(count_o), 64'd4);
    chk("t3_full", 64'(full_o), 64'd1);
    @(negedge clk);
    chk("t3_drop_pulse", 64'(drop_o), 64'd0);
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      launch_check(T_LOGON, NH'(i));
      chk("t3_comp", 64'(comp_o), 64'(16'h100 + i));
      complete();
    end
    chk("t3_empty", 64'({full_o, count_o}), 64'd0);

    // Heartbeat merge per host
    busy = 1'b1;
    push(T_HB, 8'd1, 16'h0001, 8'd2);
    push(T_HB, 8'd1, 16'h0002, 8'd2);
    chk("t4_dup_drop", 64'(drop_o), 64'd1);
    chk("t4_dup_count", 64'(count_o), 64'd1);
    push(T_HB, 8'd3, 16'h0003, 8'd2);
    chk("t4_other_host_drop", 64'(drop_o), 64'd0);
    chk("t4_other_host_count", 64'(count_o), 64'd2);
    busy = 1'b0;
    launch_check(T_HB, 8'd1); complete();
    launch_check(T_HB, 8'd3); complete();

    // Watchdog: no done, error WDOG cycles after entering the wait
    busy = 1'b1;
    push(T_LOGOUT, 8'd5, 16'h0505, 8'd3);
    push(T_LOGON, 8'd6, 16'h0606, 8'd3);
    busy = 1'b0;
    launch_check(T_LOGOUT, 8'd5);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (wdog_err_o) break;
    end
    chk("t5_wdog_latency", 64'(cyc), 64'(WDOG + 1));
    launch_check(T_LOGON, 8'd6); complete();

    // Async reset while waiting with two entries queued
    busy = 1'b1;
    push(T_LOGON, 8'd1, 16'h0021, 8'd5);
    push(T_LOGON, 8'd2, 16'h0022, 8'd5);
    push(T_LOGON, 8'd3, 16'h0023, 8'd5);
    busy = 1'b0;
    wait_start(ok);
    @(negedge clk);
    chk("t6_count_before_rst", 64'(count_o), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_outputs", 64'({start_o, msg_type_o, host_o, comp_o, size_o}), 64'd0);
    chk("t6_rst_count_full", 64'({full_o, count_o}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_idle_after_rst", 64'({start_o, count_o}), 64'd0);
    push(T_RESEND, 8'd7, 16'h0777, 8'd6);
    launch_check(T_RESEND, 8'd7); complete();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
